gram_scanout_reader: RTL



---
 rtl/gram_scanout_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gram_scanout_reader.sv
// Scan-out reader: streams LCD GRAM from SDRAM in 4-word bursts into a small
// pixel FIFO and pops one RGB565 pixel per request for the TFT output stage.
module gram_scanout_reader #(
  parameter int          H_PIXELS   = 480,
  parameter int          V_LINES    = 800,
  parameter logic [23:0] BASE_ADDR  = 24'd0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iFrameStart,
  output logic [23:0] oSDRAM_Rd_Addr,
  output logic        oSDRAM_Rd_Req,
  input  logic        iSDRAM_Rd_Done,
  input  logic [15:0] iSDRAM_Data1,
  input  logic [15:0] iSDRAM_Data2,
  input  logic [15:0] iSDRAM_Data3,
  input  logic [15:0] iSDRAM_Data4,
  input  logic        iPixelReq,
  output logic [15:0] oPixelData,
  output logic        oPixelValid,
  output logic        oUnderflow,
  output logic        oFrameDone
);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [23:0] LAST_ADDR = BASE_ADDR + 24'(H_PIXELS * V_LINES - 4);
  localparam logic [CW-1:0] SPACE_MAX = CW'(FIFO_DEPTH - 4);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} state_t;

  state_t                      state;
  logic [FIFO_DEPTH-1:0][15:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic [3:0][15:0]            burst;
  logic                        push, pop, restart;

  assign burst = {iSDRAM_Data4, iSDRAM_Data3, iSDRAM_Data2, iSDRAM_Data1};
  assign pop   = iPixelReq && (count != '0);
  assign push  = (state == WAIT) && iSDRAM_Rd_Done && !iFrameStart;
  // A frame start while a burst is in flight waits for that burst's done.
  assign restart = (iFrameStart && (state == IDLE || state == FETCH || state == DONE)) ||
                   (iSDRAM_Rd_Done && (state == DRAIN || (state == WAIT && iFrameStart)));

  always_ff @(posedge clk) begin
    if (push)
      for (int k = 0; k < 4; k++) mem[wr_ptr + PW'(k)] <= burst[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      oSDRAM_Rd_Req  <= 1'b0;
      oSDRAM_Rd_Addr <= BASE_ADDR;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      oPixelData     <= '0;
      oPixelValid    <= 1'b0;
      oUnderflow     <= 1'b0;
      oFrameDone     <= 1'b0;
    end else if (!en) begin
      state          <= IDLE;
      oSDRAM_Rd_Req  <= 1'b0;
      oSDRAM_Rd_Addr <= BASE_ADDR;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      oPixelData     <= '0;
      oPixelValid    <= 1'b0;
      oUnderflow     <= 1'b0;
      oFrameDone     <= 1'b0;
    end else begin
      oFrameDone  <= 1'b0;
      oPixelValid <= iPixelReq;
      if (iPixelReq) oPixelData <= pop ? mem[rd_ptr] : 16'h0000;

      // Pop sees the pre-flush head; words pushed this cycle are not yet visible.
      if (restart) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(4);
        count <= count + (push ? CW'(4) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      end

      if (iPixelReq && count == '0) oUnderflow <= 1'b1;
      else if (restart)             oUnderflow <= 1'b0;

      case (state)
        IDLE, DONE: if (iFrameStart) begin
          oSDRAM_Rd_Addr <= BASE_ADDR;
          state          <= FETCH;
        end
        FETCH: if (iFrameStart) begin
          oSDRAM_Rd_Addr <= BASE_ADDR;
        end else if (count <= SPACE_MAX) begin
          oSDRAM_Rd_Req <= 1'b1;
          state         <= WAIT;
        end
        WAIT: if (iSDRAM_Rd_Done) begin
          oSDRAM_Rd_Req <= 1'b0;
          if (iFrameStart) begin
            oSDRAM_Rd_Addr <= BASE_ADDR;
            state          <= FETCH;
          end else if (oSDRAM_Rd_Addr == LAST_ADDR) begin
            oFrameDone <= 1'b1;
            state      <= DONE;
          end else begin
            oSDRAM_Rd_Addr <= oSDRAM_Rd_Addr + 24'd4;
            state          <= FETCH;
          end
        end else if (iFrameStart) begin
          state <= DRAIN;
        end
        DRAIN: if (iSDRAM_Rd_Done) begin
          oSDRAM_Rd_Req  <= 1'b0;
          oSDRAM_Rd_Addr <= BASE_ADDR;
          state          <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
